mult_radix8_seq: RTL
====================

// Module: mult_radix8_seq
// PURPOSE
//  Iterative, parametrised radix-8 Booth multiplier for the RV32IM execute stage. It supports all four
//  RV32M multiply ops (MUL/MULH/MULHSU/MULHU) and selects signed or unsigned operand extension per op.
//  It retires PP_PER_CYCLE Booth partial products per clock into a registered accumulator.
//  It sits beside the divider in MULT-DIV and reports completion with a start/finish handshake.
// PARAMETERS
//  LENGTH        32  operand/result width (multiple of 2, >=8)
//  PP_PER_CYCLE  2   Booth partial products accumulated per CALC cycle (1..G)
//  (derived) G = ceil((LENGTH+2)/3) Booth groups; N = ceil(G/PP_PER_CYCLE) CALC cycles (32/2: G=12, N=6)
// PORTS
//  CLK          in   1        clock, rising edge
//  RST          in   1        synchronous reset, active-high
//  ENABLE_MULT  in   1        start request; sampled only in IDLE
//  FUNCT3       in   3        000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx treated as MUL
//  OPER_A       in   LENGTH   multiplicand (rs1)
//  OPER_B       in   LENGTH   multiplier (rs2), Booth-recoded
//  MULT_O       out  LENGTH   result: low half for MUL, high half otherwise
//  MULT_FINISH  out  1        one-cycle pulse; MULT_O valid in that cycle
//  MULT_BUSY    out  1        high in CALC and DONE
// BEHAVIOUR
//  - Reset: state=IDLE; MULT_O=0, MULT_FINISH=0, MULT_BUSY=0; accumulator, counter and operand regs cleared.
//  - FSM: IDLE -(ENABLE_MULT)-> CALC -(cnt==N-1)-> DONE -> IDLE (unconditional).
//  - Start edge (IDLE && ENABLE_MULT): latch FUNCT3. Extend A and B to LENGTH+2 bits.
//    Sign-extend A for MUL/MULH/MULHSU, zero-extend for MULHU. Sign-extend B for MUL/MULH only.
//    Clear the 2*LENGTH+4-bit accumulator; cnt=0.
//  - Booth digit k uses B bits {3k+2..3k, 3k-1} (bit -1 = 0) and takes a value in {-4..+4}.
//    Partial product = digit*A_ext, formed with a registered 3A.
//    It is sign-extended to accumulator width, shifted left 3k, and added to the accumulator.
//  - CALC: each cycle adds digits cnt*P .. cnt*P+P-1. Digits >= G contribute 0. cnt increments.
//  - DONE: MULT_O <= acc[LENGTH-1:0] (FUNCT3=000/1xx) or acc[2*LENGTH-1:LENGTH]; MULT_FINISH=1 this cycle only.
//  - Latency: start edge at cycle 0 -> MULT_FINISH high in cycle N+1 (32/2: cycle 7). Throughput: 1 op per N+2 cycles.
//  - MULT_O holds its last value until the next DONE. It does not change in IDLE or CALC.
//  - ENABLE_MULT asserted while MULT_BUSY: ignored, no queuing. Caller re-asserts after MULT_FINISH.
//  - ENABLE_MULT held high continuously: a new op starts on the IDLE cycle that follows DONE.
//  - Operand/FUNCT3 changes after the start edge: no effect on the op in flight.
//  - RST mid-op (CALC or DONE): next cycle IDLE, MULT_FINISH=0, MULT_O=0; the op is discarded.
//  - Accumulator carries wrap modulo 2^(2*LENGTH+4). Only bits [2*LENGTH-1:0] are architectural.
// CONFIGURATION
//  MULT_RADIX8_ZERO_SKIP_EN defined: a start with OPER_A==0 or OPER_B==0 skips CALC and goes IDLE -> DONE.
//    MULT_O=0 and MULT_FINISH is high in cycle 1.
//  Not defined: zero operands take the full N+1 cycles. Results are identical either way.
// TESTING
//  1 MUL A=7, B=0xFFFFFFFD (-3) -> MULT_O=0xFFFFFFEB, MULT_FINISH one pulse in cycle 7, BUSY high cycles 1-7.
//  2 MULH A=B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
//  3 MUL A=0x12345678, B=0x9ABCDEF0; ENABLE_MULT re-pulsed with A=B=1 in cycles 2-5
//    -> single finish, MULT_O=0x242D2080.
//  4 Start MULHU, assert RST in cycle 3 -> cycle 4: BUSY=0, MULT_O=0, no MULT_FINISH.
//    A fresh MUL 3*5 then returns 15.
//  5 ENABLE_MULT held high over two ops (MUL 2*3, then MULH -1*-1) -> finishes in cycles 7 and 15.
//    Results 6, then 0x00000000.
//  6 MUL A=0, B=0xDEADBEEF -> 0; MULT_FINISH in cycle 1 with ZERO_SKIP_EN, cycle 7 without.
//  Scoreboard: random FUNCT3/operands vs 64-bit reference product, LENGTH=16/32, PP_PER_CYCLE=1/2/4.

Source files
------------

// File: rtl/mult_radix8_seq.sv
// rtl/mult_radix8_seq.sv - iterative radix-8 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU (optional MULT_RADIX8_ZERO_SKIP_EN)
module mult_radix8_seq #(
    parameter int LENGTH       = 32,
    parameter int PP_PER_CYCLE = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE_MULT,
    input  logic [2:0]        FUNCT3,
    input  logic [LENGTH-1:0] OPER_A,
    input  logic [LENGTH-1:0] OPER_B,
    output logic [LENGTH-1:0] MULT_O,
    output logic              MULT_FINISH,
    output logic              MULT_BUSY
);

    localparam int EW = LENGTH + 2;
    localparam int AW = 2 * LENGTH + 4;
    localparam int G  = (LENGTH + 4) / 3;
    localparam int N  = (G + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = 3 * G + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [EW-1:0]     a_q, a_d;
    logic [EW-1:0]     b_q, b_d;
    logic [AW-1:0]     a3_q, a3_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [LENGTH-1:0] mult_o_q, mult_o_d;

    logic [1:0]        op_in;
    logic [EW-1:0]     a_ext_in;
    logic [EW-1:0]     b_ext_in;
    logic [AW-1:0]     a_in_sx;
    logic [AW-1:0]     a_sx;
    logic [BW-1:0]     b_pad;
    logic [AW-1:0]     pp_sum;
    logic [AW-1:0]     acc_next;
    logic              hi_sel;

    // 1xx decodes as MUL; A is signed unless MULHU, B is signed only for MUL/MULH
    assign op_in    = FUNCT3[2] ? 2'b00 : FUNCT3[1:0];
    assign a_ext_in = {{2{OPER_A[LENGTH-1] & (op_in != 2'b11)}}, OPER_A};
    assign b_ext_in = {{2{OPER_B[LENGTH-1] & ~op_in[1]}}, OPER_B};
    assign a_in_sx  = AW'($signed(a_ext_in));
    assign a_sx     = AW'($signed(a_q));
    // implicit bit -1 is zero; upper groups see the sign of the extended multiplier
    assign b_pad    = BW'($signed({b_q, 1'b0}));
    assign hi_sel   = ~f3_q[2] & (f3_q[1:0] != 2'b00);
    assign acc_next = acc_q + pp_sum;

    // sum of this cycle's shifted Booth partial products; groups past G add nothing
    always_comb begin
        int             k;
        logic [3:0]     grp;
        logic [AW-1:0]  mag;
        logic           neg;
        pp_sum = '0;
        k      = 0;
        grp    = '0;
        mag    = '0;
        neg    = 1'b0;
        for (int j = 0; j < PP_PER_CYCLE; j++) begin
            k   = int'(cnt_q) * PP_PER_CYCLE + j;
            mag = '0;
            neg = 1'b0;
            if (k < G) begin
                grp = b_pad[3*k +: 4];
                case (grp)
                    4'b0001, 4'b0010: mag = a_sx;
                    4'b0011, 4'b0100: mag = a_sx << 1;
                    4'b0101, 4'b0110: mag = a3_q;
                    4'b0111:          mag = a_sx << 2;
                    4'b1000:          begin mag = a_sx << 2; neg = 1'b1; end
                    4'b1001, 4'b1010: begin mag = a3_q;      neg = 1'b1; end
                    4'b1011, 4'b1100: begin mag = a_sx << 1; neg = 1'b1; end
                    4'b1101, 4'b1110: begin mag = a_sx;      neg = 1'b1; end
                    default:          mag = '0;
                endcase
                pp_sum = pp_sum + ((neg ? -mag : mag) << (3 * k));
            end
        end
    end

    // next-state and datapath load decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        a_d      = a_q;
        b_d      = b_q;
        a3_d     = a3_q;
        acc_d    = acc_q;
        mult_o_d = mult_o_q;
        case (state_q)
            S_IDLE: begin
                if (ENABLE_MULT) begin
                    f3_d  = FUNCT3;
                    a_d   = a_ext_in;
                    b_d   = b_ext_in;
                    a3_d  = a_in_sx + (a_in_sx << 1);
                    acc_d = '0;
                    cnt_d = '0;
`ifdef MULT_RADIX8_ZERO_SKIP_EN
                    if (OPER_A == '0 || OPER_B == '0) begin
                        state_d  = S_DONE;
                        mult_o_d = '0;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = S_DONE;
                    // result is registered on entry to DONE so it is valid with the finish pulse
                    mult_o_d = hi_sel ? acc_next[2*LENGTH-1:LENGTH] : acc_next[LENGTH-1:0];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a3_q     <= '0;
            acc_q    <= '0;
            mult_o_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            a3_q     <= a3_d;
            acc_q    <= acc_d;
            mult_o_q <= mult_o_d;
        end
    end

    assign MULT_O      = mult_o_q;
    assign MULT_FINISH = (state_q == S_DONE);
    assign MULT_BUSY   = (state_q != S_IDLE);

endmodule
